fcl_param_loader: RTL and testbench

FCL_PARAM_LOADER -- requirements
Module: fcl_param_loader

---
 rtl/fcl_param_loader.sv | 154 +++++++++++++++
 tb/tb_fcl_param_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcl_param_loader.sv
// Streams one fully-connected layer frame (inputs, weights, biases) into registered arrays,
// kicks the FCL controller and waits for it to finish before accepting the next frame.
module fcl_param_loader #(
    parameter int unsigned INPUT_NEURON_COUNT  = 60,
    parameter int unsigned OUTPUT_NEURON_COUNT = 50
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      s_valid,
    output logic                                                      s_ready,
    input  logic [15:0]                                               s_data,
    input  logic                                                      s_last,
    output logic [16*INPUT_NEURON_COUNT-1:0]                          inputs,
    output logic [16*OUTPUT_NEURON_COUNT*INPUT_NEURON_COUNT-1:0]      weights,
    output logic [16*OUTPUT_NEURON_COUNT-1:0]                         biases,
    output logic                                                      start,
    input  logic                                                      done,
    output logic                                                      layer_done,
    output logic                                                      frame_err,
    output logic [7:0]                                                frames_loaded
);

    localparam int unsigned IN = INPUT_NEURON_COUNT;
    localparam int unsigned OUT = OUTPUT_NEURON_COUNT;
    localparam int unsigned WN = IN * OUT;
    localparam int unsigned IW = (IN > 1) ? $clog2(IN) : 1;
    localparam int unsigned WW = (WN > 1) ? $clog2(WN) : 1;
    localparam int unsigned BW = (OUT > 1) ? $clog2(OUT) : 1;

    typedef enum logic [2:0] {LOAD_IN, LOAD_W, LOAD_B, KICK, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           in_cnt_q, in_cnt_d;
    logic [WW-1:0]           w_cnt_q, w_cnt_d;
    logic [BW-1:0]           b_cnt_q, b_cnt_d;
    logic [7:0]              frames_q, frames_d;
    logic [16*IN-1:0]        inputs_q;
    logic [16*WN-1:0]        weights_q;
    logic [16*OUT-1:0]       biases_q;
    logic                    accept;

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        w_cnt_d    = w_cnt_q;
        b_cnt_d    = b_cnt_q;
        frames_d   = frames_q;
        s_ready    = 1'b0;
        start      = 1'b0;
        layer_done = 1'b0;
        frame_err  = 1'b0;
        accept     = 1'b0;
        case (state_q)
            LOAD_IN: begin
                s_ready = ~rst;
                accept  = s_valid & ~rst;
                if (accept) begin
                    if (s_last) begin
                        frame_err = 1'b1;
                    end else if (in_cnt_q == IW'(IN - 1)) begin
                        in_cnt_d = '0;
                        state_d  = LOAD_W;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            LOAD_W: begin
                s_ready = ~rst;
                accept  = s_valid & ~rst;
                if (accept) begin
                    if (s_last) begin
                        frame_err = 1'b1;
                    end else if (w_cnt_q == WW'(WN - 1)) begin
                        w_cnt_d = '0;
                        state_d = LOAD_B;
                    end else begin
                        w_cnt_d = w_cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                s_ready = ~rst;
                accept  = s_valid & ~rst;
                if (accept) begin
                    // The final bias word must carry s_last; any mismatch discards the frame.
                    if (b_cnt_q == BW'(OUT - 1)) begin
                        b_cnt_d = '0;
                        if (s_last) state_d = KICK;
                        else        frame_err = 1'b1;
                    end else if (s_last) begin
                        frame_err = 1'b1;
                    end else begin
                        b_cnt_d = b_cnt_q + 1'b1;
                    end
                end
            end
            KICK: begin
                start    = 1'b1;
                frames_d = frames_q + 8'd1;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    layer_done = 1'b1;
                    state_d    = LOAD_IN;
                    in_cnt_d   = '0;
                    w_cnt_d    = '0;
                    b_cnt_d    = '0;
                end
            end
            default: state_d = LOAD_IN;
        endcase
        if (frame_err) begin
            state_d  = LOAD_IN;
            in_cnt_d = '0;
            w_cnt_d  = '0;
            b_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD_IN;
            in_cnt_q  <= '0;
            w_cnt_q   <= '0;
            b_cnt_q   <= '0;
            frames_q  <= '0;
            inputs_q  <= '0;
            weights_q <= '0;
            biases_q  <= '0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            w_cnt_q  <= w_cnt_d;
            b_cnt_q  <= b_cnt_d;
            frames_q <= frames_d;
            if (accept) begin
                case (state_q)
                    LOAD_IN: inputs_q[16*int'(in_cnt_q) +: 16]  <= s_data;
                    LOAD_W:  weights_q[16*int'(w_cnt_q) +: 16]  <= s_data;
                    LOAD_B:  biases_q[16*int'(b_cnt_q) +: 16]   <= s_data;
                    default: ;
                endcase
            end
        end
    end

    assign inputs        = inputs_q;
    assign weights       = weights_q;
    assign biases        = biases_q;
    assign frames_loaded = frames_q;

endmodule

// File: tb/tb_fcl_param_loader.sv
// Self-checking bench for fcl_param_loader with IN=3, OUT=2 (11-word frames).
module tb_fcl_param_loader;

    localparam int IN  = 3;
    localparam int OUT = 2;
    localparam int WN  = IN * OUT;
    localparam int N   = IN + WN + OUT;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [15:0]       s_data;
    logic              s_last;
    logic [16*IN-1:0]  inputs;
    logic [16*WN-1:0]  weights;
    logic [16*OUT-1:0] biases;
    logic              start;
    logic              done;
    logic              layer_done;
    logic              frame_err;
    logic [7:0]        frames_loaded;

    fcl_param_loader #(
        .INPUT_NEURON_COUNT(IN),
        .OUTPUT_NEURON_COUNT(OUT)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .inputs(inputs), .weights(weights), .biases(biases),
        .start(start), .done(done), .layer_done(layer_done), .frame_err(frame_err),
        .frames_loaded(frames_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sec;
        int          idx;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        string       name;
        logic [15:0] base;
        int          last_at;
        bit          toggle;
        int          nwords;
        bit          exp_start;
    } vec_t;

    exp_t        sbq[$];
    logic [15:0] m_in[IN];
    logic [15:0] m_w[WN];
    logic [15:0] m_b[OUT];
    int          mpos;
    logic [7:0]  m_frames;
    int          tests_run = 0;
    int          tests_failed = 0;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        foreach (m_in[i]) m_in[i] = '0;
        foreach (m_w[i])  m_w[i]  = '0;
        foreach (m_b[i])  m_b[i]  = '0;
        sbq.delete();
        mpos = 0;
        m_frames = '0;
    endtask

    task automatic check_model();
        for (int i = 0; i < IN; i++)  check("inputs_hold",  inputs[i*16 +: 16],  m_in[i]);
        for (int i = 0; i < WN; i++)  check("weights_hold", weights[i*16 +: 16], m_w[i]);
        for (int i = 0; i < OUT; i++) check("biases_hold",  biases[i*16 +: 16],  m_b[i]);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sec)
                0:       check("sb_inputs",  inputs[e.idx*16 +: 16],  e.val);
                1:       check("sb_weights", weights[e.idx*16 +: 16], e.val);
                default: check("sb_biases",  biases[e.idx*16 +: 16],  e.val);
            endcase
        end
    endtask

    task automatic record(input logic [15:0] d);
        exp_t e;
        e.val = d;
        if (mpos < IN) begin
            e.sec = 0; e.idx = mpos; m_in[mpos] = d;
        end else if (mpos < IN + WN) begin
            e.sec = 1; e.idx = mpos - IN; m_w[mpos - IN] = d;
        end else begin
            e.sec = 2; e.idx = mpos - IN - WN; m_b[mpos - IN - WN] = d;
        end
        sbq.push_back(e);
        mpos++;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic send_word(input logic [15:0] d, input bit last);
        int  waited = 0;
        bit  final_w;
        bit  err;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            check("accept_timeout", s_ready, 1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            @(posedge clk); #1;
            return;
        end
        final_w = (mpos == N - 1);
        err     = last ? !final_w : final_w;
        check("frame_err", frame_err, err);
        check("no_start_while_loading", start, 0);
        record(d);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (err) begin
            mpos = 0;
            drain();
        end else if (final_w) begin
            mpos = 0;
        end
    endtask

    task automatic send_frame(input logic [15:0] base, input int last_at, input bit toggle,
                              input int nwords);
        for (int i = 0; i < nwords; i++) begin
            if (toggle) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            send_word(base + 16'(i + 1), (i + 1 == last_at));
        end
    endtask

    task automatic expect_kick(input bit exp);
        @(negedge clk);
        check("start", start, exp);
        check("frames_pre", frames_loaded, m_frames);
        if (exp) begin
            drain();
            m_frames = m_frames + 8'd1;
            @(posedge clk); #1;
            @(negedge clk);
            check("start_once", start, 0);
            check("frames_loaded", frames_loaded, m_frames);
        end
        @(posedge clk); #1;
    endtask

    task automatic finish_layer(input int idle, input bit bombard);
        for (int k = 0; k < idle; k++) begin
            s_valid = bombard;
            s_data  = 16'hFFFF;
            @(negedge clk);
            check("ready_in_wait", s_ready, 0);
            check("layer_done_idle", layer_done, 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        done    = 1'b1;
        @(negedge clk);
        check("layer_done", layer_done, 1);
        @(posedge clk); #1;
        done = 1'b0;
        @(negedge clk);
        check("ready_after_done", s_ready, 1);
        check("layer_done_once", layer_done, 0);
        check_model();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{"full",       16'h0000, 11, 1'b0, 11, 1'b1};
        vecs[1] = '{"toggle",     16'h0000, 11, 1'b1, 11, 1'b1};
        vecs[2] = '{"early_last", 16'h0020,  5, 1'b0,  5, 1'b0};
        vecs[3] = '{"no_last",    16'h0030,  0, 1'b0, 11, 1'b0};
        vecs[4] = '{"after_err",  16'h0050, 11, 1'b0, 11, 1'b1};

        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; done = 1'b0;
        clear_model();
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_start", start, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frames", frames_loaded, 0);
        check_model();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].base, vecs[v].last_at, vecs[v].toggle, vecs[v].nwords);
            expect_kick(vecs[v].exp_start);
            if (vecs[v].exp_start) finish_layer(10, 1'b1);
            else                   check_model();
        end

        // Partial frame, stray done, then reset mid-frame.
        send_frame(16'h0060, 0, 1'b0, 6);
        done = 1'b1;
        @(negedge clk);
        check("done_ignored", layer_done, 0);
        check("ready_loading", s_ready, 1);
        @(posedge clk); #1;
        done = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        clear_model();
        check("midrst_ready", s_ready, 0);
        check("midrst_start", start, 0);
        check("midrst_frames", frames_loaded, 0);
        check("midrst_frame_err", frame_err, 0);
        check_model();
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(16'h0070, 11, 1'b0, 11);
        expect_kick(1'b1);
        finish_layer(2, 1'b0);

        // Run frames until the launch counter wraps to zero.
        for (int f = 0; f < 300 && m_frames != 8'd0; f++) begin
            send_frame(16'(f * 16), 11, 1'b0, 11);
            expect_kick(1'b1);
            finish_layer(0, 1'b0);
        end
        check("frames_wrap", frames_loaded, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
